// File: rtl/scratch_pad_pkg.sv
// Shared types and constants for the scratch-pad port arbiter.
package scratch_pad_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef logic req_id_t;

  // Requester index of a one-hot (or zero) two-requester grant vector.
  function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/scratch_pad_port_arbiter_rr_arb2.sv
// Two-input round-robin grant logic; the last-grant pointer lives in the caller.
module rr_arb2
  import scratch_pad_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_id_t            last_grant_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On contention the requester that did not win last time goes first.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/scratch_pad_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters.
// Optional RAM clear after reset: define SCRATCH_PAD_ARB_CLEAR_EN.
module scratch_pad_port_arbiter
  import scratch_pad_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_id,
  output logic [WIDTH-1:0]              rsp_data,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_addr_a,
  output logic [WIDTH-1:0]              ram_d,
  input  logic [WIDTH-1:0]              ram_q_a,
  output logic                          init_done
);

`ifdef SCRATCH_PAD_ARB_CLEAR_EN
  localparam int                    DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam state_e                RESET_STATE = ST_INIT;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
`else
  localparam state_e                RESET_STATE = ST_RUN;
`endif

  state_e                state_q, state_d;
  req_id_t               last_grant_q;
  logic                  rsp_valid_q;
  req_id_t               rsp_id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      d_q, d_d;

  logic [NUM_REQ-1:0]    grant;
  logic                  run_en;
  logic                  xfer;
  req_id_t               xfer_id;
  logic                  xfer_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;

  rr_arb2 u_arb (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Gating with rst_n keeps req_ready and ram_wr_en low while reset is held,
  // even though the state register already reads RUN in the no-clear build.
  assign run_en    = rst_n && (state_q == ST_RUN);
  assign req_ready = run_en ? grant : '0;
  assign xfer      = |req_ready;
  assign xfer_id   = onehot_to_id(req_ready);
  assign xfer_we   = req_we[xfer_id];
  assign sel_addr  = req_addr[xfer_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[xfer_id*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    ram_wr_en = 1'b0;
    addr_d    = addr_q;
    d_d       = d_q;
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
    clr_d     = clr_q;
    if (rst_n && state_q == ST_INIT) begin
      ram_wr_en = 1'b1;
      addr_d    = clr_q;
      d_d       = '0;
      clr_d     = clr_q + 1'b1;
      if (clr_q == LAST_ADDR) state_d = ST_RUN;
    end
`endif
    if (xfer) begin
      ram_wr_en = xfer_we;
      addr_d    = sel_addr;
      if (xfer_we) d_d = sel_wdata;
    end
  end

  // Address and data are driven combinationally in the grant cycle and held afterwards.
  assign ram_addr_a = addr_d;
  assign ram_d      = d_d;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      addr_q       <= '0;
      d_q          <= '0;
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
      clr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      d_q         <= d_d;
      rsp_valid_q <= xfer && !xfer_we;
      if (xfer) last_grant_q <= xfer_id;
      if (xfer && !xfer_we) rsp_id_q <= xfer_id;
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_q_a;

`ifdef SCRATCH_PAD_ARB_CLEAR_EN
  assign init_done = (state_q == ST_RUN);
`else
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_scratch_pad_port_arbiter.sv
// Directed bench for scratch_pad_port_arbiter with a registered-read RAM model.
module tb_scratch_pad_port_arbiter;

  localparam int DEPTH = 256;
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid, req_ready, req_we;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid, rsp_id;
  logic [63:0]  rsp_data, ram_d, ram_q_a;
  logic         ram_wr_en, init_done;
  logic [7:0]   ram_addr_a;
  logic [63:0]  mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  scratch_pad_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .ram_wr_en  (ram_wr_en),
    .ram_addr_a (ram_addr_a),
    .ram_d      (ram_d),
    .ram_q_a    (ram_q_a),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-A RAM: synchronous write, registered read-first output.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr_a] <= ram_d;
    ram_q_a <= mem[ram_addr_a];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'h0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'h0);
    check({tag, "_wr_en"}, 64'(ram_wr_en), 64'h0);
    check({tag, "_addr"}, 64'(ram_addr_a), 64'h0);
    check({tag, "_d"}, ram_d, 64'h0);
    check({tag, "_init_done"}, 64'(init_done), CLEAR_EN ? 64'h0 : 64'h1);
  endtask

  initial begin
    logic [1:0]  exp_gnt [3];
    logic [7:0]  exp_addr [3];
    logic [63:0] exp_data [3];
    exp_gnt  = '{2'b10, 2'b01, 2'b10};
    exp_addr = '{8'd2, 8'd1, 8'd2};
    exp_data = '{64'h2222, 64'h1111, 64'h2222};

    // Reset with requester 1 already asking for a read of address 0.
    rst_n = 1'b1;
    drive(2'b10, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;

`ifdef SCRATCH_PAD_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("clr_wr_en", 64'(ram_wr_en), 64'h1);
      check("clr_addr", 64'(ram_addr_a), 64'(i));
      check("clr_d", ram_d, 64'h0);
      check("clr_ready", 64'(req_ready), 64'h0);
      check("clr_init_done", 64'(init_done), 64'h0);
    end
`endif

    // First RUN cycle: the held request is granted.
    @(negedge clk);
    check("run0_init_done", 64'(init_done), 64'h1);
    check("run0_ready", 64'(req_ready), 64'h2);
    check("run0_wr_en", 64'(ram_wr_en), 64'h0);
    tick();
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("run0_rsp_valid", 64'(rsp_valid), 64'h1);
    check("run0_rsp_id", 64'(rsp_id), 64'h1);
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
    check("run0_rsp_data", rsp_data, 64'h0);
`endif

    // Requester 0 alone: write 0xA5 to address 3, then read it back.
    tick();
    drive(2'b01, 2'b01, 8'd3, 8'd0, 64'hA5, 64'h0);
    @(negedge clk);
    check("wr0_ready", 64'(req_ready), 64'h1);
    check("wr0_wr_en", 64'(ram_wr_en), 64'h1);
    check("wr0_addr", 64'(ram_addr_a), 64'h3);
    check("wr0_d", ram_d, 64'hA5);
    check("wr0_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    drive(2'b01, 2'b00, 8'd3, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("rd0_ready", 64'(req_ready), 64'h1);
    check("rd0_wr_en", 64'(ram_wr_en), 64'h0);
    check("rd0_addr", 64'(ram_addr_a), 64'h3);
    check("rd0_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("rd0_rsp_valid_n1", 64'(rsp_valid), 64'h1);
    check("rd0_rsp_id", 64'(rsp_id), 64'h0);
    check("rd0_rsp_data", rsp_data, 64'hA5);
    check("idle_wr_en", 64'(ram_wr_en), 64'h0);
    check("idle_addr_hold", 64'(ram_addr_a), 64'h3);
    check("idle_d_hold", ram_d, 64'hA5);

    // Requester 1 writes 0x55 to address 7; requester 0 reads it next cycle.
    tick();
    drive(2'b10, 2'b10, 8'd0, 8'd7, 64'h0, 64'h55);
    @(negedge clk);
    check("wr1_ready", 64'(req_ready), 64'h2);
    check("wr1_wr_en", 64'(ram_wr_en), 64'h1);
    check("wr1_addr", 64'(ram_addr_a), 64'h7);
    check("wr1_d", ram_d, 64'h55);
    tick();
    drive(2'b01, 2'b00, 8'd7, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("raw_ready", 64'(req_ready), 64'h1);
    check("raw_addr", 64'(ram_addr_a), 64'h7);
    tick();
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("raw_rsp_valid", 64'(rsp_valid), 64'h1);
    check("raw_rsp_id", 64'(rsp_id), 64'h0);
    check("raw_rsp_data", rsp_data, 64'h55);

    // Contention writes: last grant was requester 0, so requester 1 goes first.
    tick();
    drive(2'b11, 2'b11, 8'd1, 8'd2, 64'h1111, 64'h2222);
    @(negedge clk);
    check("cw0_ready", 64'(req_ready), 64'h2);
    check("cw0_addr", 64'(ram_addr_a), 64'h2);
    check("cw0_d", ram_d, 64'h2222);
    tick();
    @(negedge clk);
    check("cw1_ready", 64'(req_ready), 64'h1);
    check("cw1_addr", 64'(ram_addr_a), 64'h1);
    check("cw1_d", ram_d, 64'h1111);

    // Contention reads: grants alternate, responses arrive back to back.
    tick();
    drive(2'b11, 2'b00, 8'd1, 8'd2, 64'h0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      check("cr_ready", 64'(req_ready), 64'(exp_gnt[k]));
      check("cr_wr_en", 64'(ram_wr_en), 64'h0);
      check("cr_addr", 64'(ram_addr_a), 64'(exp_addr[k]));
      check("cr_rsp_valid", 64'(rsp_valid), (k > 0) ? 64'h1 : 64'h0);
      if (k > 0) begin
        check("cr_rsp_id", 64'(rsp_id), 64'(exp_gnt[k-1][1]));
        check("cr_rsp_data", rsp_data, exp_data[k-1]);
      end
    end
    tick();
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("cr_last_rsp_valid", 64'(rsp_valid), 64'h1);
    check("cr_last_rsp_id", 64'(rsp_id), 64'h1);
    check("cr_last_rsp_data", rsp_data, 64'h2222);
    tick();
    @(negedge clk);
    check("cr_drain_rsp_valid", 64'(rsp_valid), 64'h0);

    // Requester 0 writes (pointer -> 0), then requester 1 read is cut by reset.
    tick();
    drive(2'b01, 2'b01, 8'd9, 8'd0, 64'h99, 64'h0);
    @(negedge clk);
    check("pre_wr_ready", 64'(req_ready), 64'h1);
    tick();
    drive(2'b10, 2'b00, 8'd0, 8'd9, 64'h0, 64'h0);
    @(negedge clk);
    check("mid_rd_ready", 64'(req_ready), 64'h2);
    check("mid_rd_addr", 64'(ram_addr_a), 64'h9);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    check("mid_rst_rsp_valid_after_edge", 64'(rsp_valid), 64'h0);
    check("mid_rst_ready_held", 64'(req_ready), 64'h0);

    // After reset the pointer is back at 1: requester 0 wins first contention.
    drive(2'b11, 2'b00, 8'd3, 8'd7, 64'h0, 64'h0);
    rst_n = 1'b1;
`ifdef SCRATCH_PAD_ARB_CLEAR_EN
    repeat (DEPTH) @(negedge clk);
`endif
    @(negedge clk);
    check("post_rst_ready0", 64'(req_ready), 64'h1);
    check("post_rst_addr0", 64'(ram_addr_a), 64'h3);
    tick();
    @(negedge clk);
    check("post_rst_ready1", 64'(req_ready), 64'h2);
    check("post_rst_rsp_id", 64'(rsp_id), 64'h0);
    tick();
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'h0, 64'h0);
    @(negedge clk);
    check("post_rst_rsp_id1", 64'(rsp_id), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scratch_pad_port_arbiter.md
# scratch_pad_port_arbiter

Two-requester round-robin arbiter that shares the write/read (A) port of a scratch-pad block RAM. It accepts read/write requests through valid/ready handshakes, issues at most one RAM access per cycle, and returns read data with a fixed latency and a requester tag. It sits between the requesting engines and the RAM; the RAM's B read port is not driven by this block.

## Interface
- WIDTH, 64, data word width
- ADDR_WIDTH, 8, RAM address width
- DEPTH, 1<<ADDR_WIDTH, number of RAM words
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req_we  in  2  per-requester 1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*WIDTH  requester i write data at bits [i*WIDTH +: WIDTH]
- rsp_valid  out  1  read data valid
- rsp_id  out  1  requester that issued the read
- rsp_data  out  WIDTH  read data
- ram_wr_en  out  1  to RAM write enable
- ram_addr_a  out  ADDR_WIDTH  to RAM port-A address
- ram_d  out  WIDTH  to RAM write data
- ram_q_a  in  WIDTH  from RAM port-A registered read data
- init_done  out  1  high once the block accepts requests

## Operation
- A request transfers when req_valid[i] & req_ready[i]. req_ready depends combinationally on req_valid, the priority pointer and the state. It never depends on req_ready.
- Arbitration: when only one requester is valid, it is granted. When both are valid, the requester not granted most recently wins. The pointer (last_grant) updates only on a transfer and resets to 1, so requester 0 wins the first contention.
- Granted write: ram_wr_en=1, ram_addr_a=addr, ram_d=wdata in the same cycle. No response is returned.
- Granted read: ram_wr_en=0, ram_addr_a=addr. The response follows one cycle later.
- Idle cycle: ram_wr_en=0. ram_addr_a and ram_d hold their last driven values.
- States:
  - INIT: only when clear is compiled in; see Configuration.
  - RUN: normal arbitration.
- Without the clear feature, reset goes straight to RUN.
- Requests present while in INIT or in reset are not accepted. They must be held; they are never dropped.
- Responses have no backpressure. The consumer must accept rsp_valid whenever it is asserted.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, ram_wr_en=0, ram_addr_a=0, ram_d=0, last_grant=1.
  - init_done=0 when clear is compiled in, 1 otherwise.
- Read latency: a grant in cycle N gives rsp_valid=1 in cycle N+1.
- rsp_valid and rsp_id are registered. rsp_data is ram_q_a passed through, valid only while rsp_valid=1.
- Throughput: one transfer per cycle sustained. Back-to-back reads from alternating requesters give rsp_valid high every cycle with alternating rsp_id.
- Write in cycle N, read of the same address granted in cycle N+1: the read returns the new data.
- A read and a write to the same address cannot occur in the same cycle, because there is a single grant per cycle.
- Reset asserted mid-operation clears any pending response; an in-flight read produces no rsp_valid.

## Configuration
- SCRATCH_PAD_ARB_CLEAR_EN defined:
  - After reset release the block enters INIT.
  - A clear counter walks address 0..DEPTH-1, one per cycle, with ram_wr_en=1 and ram_d=0. req_ready=0 throughout.
  - After writing DEPTH-1 the block goes to RUN and init_done rises. INIT therefore lasts exactly DEPTH cycles.
  - Reset during INIT restarts the clear from address 0.
- Macro undefined:
  - No INIT state and no clear counter; init_done is tied to 1.
  - RAM contents are undefined until written.

## Structure
- Shared package (scratch_pad_pkg) holds:
  - state enum (ST_INIT, ST_RUN)
  - requester-count constant NUM_REQ=2
  - requester-id type (1 bit)
- Sub-module rr_arb2: combinational grant from a 2-bit valid vector and last_grant; outputs a one-hot grant. Pointer register stays in the top level.

## Test plan
- Clear (macro defined, DEPTH=256): release reset → ram_wr_en high for 256 consecutive cycles, addresses 0..255, ram_d=0 → init_done rises on cycle 257; no req_ready before that.
- Single requester: requester 0 writes 0xA5 to address 3, then reads address 3 → rsp_valid one cycle after the read grant, rsp_id=0, rsp_data=0xA5.
- Contention: both requesters valid every cycle, reads to addresses 1 and 2 → grants 0,1,0,1…; responses alternate id 0/1 with no gaps.
- Write-then-read: requester 1 writes 0x55 to address 7; requester 0 reads address 7 in the next cycle → rsp_data=0x55, rsp_id=0.
- Hold during INIT: req_valid[1]=1 asserted during clear → no transfer until init_done; then granted in the first RUN cycle.
- Mid-read reset: assert rst_n=0 the cycle after a read grant → rsp_valid stays 0; all outputs at reset values.
